// File: rtl/inst_player_pkg.sv
// rtl/inst_player_pkg.sv - shared state encodings, opcode field and helpers for inst_player
package inst_player_pkg;

   // Sequencer states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_SETUP = 3'd2;
   localparam logic [2:0] ST_PULSE = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Opcode field of an instruction word; SEND uses its own strobe
   localparam int         OP_MSB  = 7;
   localparam int         OP_LSB  = 6;
   localparam logic [1:0] OP_SEND = 2'b11;

   function automatic logic is_send(input logic [7:0] inst);
      return inst[OP_MSB:OP_LSB] == OP_SEND;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/inst_player_prog_ram.sv
// rtl/inst_player_prog_ram.sv - program image RAM, sync write, sync read with one-cycle latency
module inst_player_prog_ram
   import inst_player_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Write port and registered read port; contents are not reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/inst_player.sv
// rtl/inst_player.sv - instruction sequencer replaying a stored program into the calculator inputs
module inst_player
   import inst_player_pkg::*;
#(
   parameter  int DEPTH     = 16,
   parameter  int SETUP_CYC = 150000,
   parameter  int PULSE_CYC = 300000,
   parameter  int GAP_CYC   = 150000,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          start,
   input  logic          abort,
   output logic [7:0]    sw,
   output logic          btnS,
   output logic          send,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] idx,
   output logic          err
);

   localparam int            CW       = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
   localparam logic [7:0]    MAX_N    = 8'(DEPTH - 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [7:0]    count_reg;
   logic [AW-1:0] n_eff;
   logic [AW-1:0] raddr;
   logic [7:0]    rdata;
   logic          ram_we;
   logic          last_cyc;

   // Counts larger than the RAM can hold are clamped to the last word
   assign n_eff    = (count_reg > MAX_N) ? LAST_IDX : count_reg[AW-1:0];
   // Read address runs one step ahead so the word is ready during FETCH
   assign raddr    = (state == ST_IDLE) ? AW'(1) : idx + AW'(1);
   assign ram_we   = wr_en && !busy && (wr_addr != '0);
   assign last_cyc = (cnt == CW'(1));

   inst_player_prog_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Sequencer FSM with delay counter, count register, index and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         count_reg <= '0;
         sw        <= '0;
         btnS      <= 1'b0;
         send      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         idx       <= '0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_en && busy) err <= 1'b1;
         if (wr_en && !busy && (wr_addr == '0)) count_reg <= wr_data;
         if (abort) begin
            state <= ST_IDLE;
            btnS  <= 1'b0;
            send  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     err <= (count_reg > MAX_N);
                     if (count_reg == 8'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        idx   <= AW'(1);
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                     end
                  end
               end
               ST_FETCH: begin
                  sw    <= rdata;
                  cnt   <= SETUP_LD;
                  state <= ST_SETUP;
               end
               ST_SETUP: begin
                  if (last_cyc) begin
                     if (is_send(sw)) send <= 1'b1;
                     else             btnS <= 1'b1;
                     cnt   <= PULSE_LD;
                     state <= ST_PULSE;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               ST_PULSE: begin
                  if (last_cyc) begin
                     btnS  <= 1'b0;
                     send  <= 1'b0;
                     cnt   <= GAP_LD;
                     state <= ST_GAP;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               ST_GAP: begin
                  if (last_cyc) begin
                     if (idx >= n_eff) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                     end else begin
                        idx   <= idx + AW'(1);
                        state <= ST_FETCH;
                     end
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_player.sv
// tb/tb_inst_player.sv - self-checking bench for inst_player against a timeline reference model
module tb_inst_player;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int SETUP = 2;
   localparam int PULSE = 3;
   localparam int GAP   = 1;
   localparam int P     = 1 + SETUP + PULSE + GAP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    sw;
   logic          btnS, send, busy, done, err;
   logic [AW-1:0] idx;

   int         total = 0;
   int         bad = 0;
   logic [7:0] prog [DEPTH];
   int         count_model = 0;
   logic [7:0] last_sw = 8'h00;

   inst_player #(
      .DEPTH(DEPTH), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .GAP_CYC(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .abort(abort), .sw(sw), .btnS(btnS), .send(send),
      .busy(busy), .done(done), .idx(idx), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = a[AW-1:0];
      wr_data = d[7:0];
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic load(input int n);
      wr(0, n);
      for (int k = 1; k <= n && k < DEPTH; k++) wr(k, int'(prog[k]));
   endtask

   // kind: 0 plain run, 1 abort at cycle inj, 2 start+write while busy at inj, 3 async reset at inj
   task automatic play(input int kind, input int inj);
      int         neff;
      int         len;
      logic       exp_err;
      logic       aborted;
      logic       rst_hit;
      logic [7:0] sw_ab;
      neff    = (count_model > DEPTH - 1) ? DEPTH - 1 : count_model;
      exp_err = (count_model > DEPTH - 1);
      len     = P * neff + 3;
      aborted = 1'b0;
      rst_hit = 1'b0;
      sw_ab   = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 1; j <= len; j++) begin
         int         k;
         int         ph;
         logic [7:0] e_sw;
         logic       e_btn, e_send, e_busy, e_done, strobe;
         k  = (j - 1) / P + 1;
         ph = (j - 1) % P;
         if (j <= P * neff) begin
            e_sw   = (ph == 0) ? ((k == 1) ? last_sw : prog[k-1]) : prog[k];
            strobe = (ph >= 1 + SETUP) && (ph < 1 + SETUP + PULSE);
            e_send = strobe && (prog[k][7:6] == 2'b11);
            e_btn  = strobe && (prog[k][7:6] != 2'b11);
            e_busy = 1'b1;
            e_done = 1'b0;
         end else begin
            e_sw   = (neff > 0) ? prog[neff] : last_sw;
            e_send = 1'b0;
            e_btn  = 1'b0;
            e_busy = 1'b0;
            e_done = (j == 1 + P * neff);
         end
         if (aborted) begin
            e_sw   = sw_ab;
            e_send = 1'b0;
            e_btn  = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
         end
         check($sformatf("outs j=%0d", j), {sw, btnS, send, busy, done, err},
               {e_sw, e_btn, e_send, e_busy, e_done, exp_err});
         check("excl", {31'd0, btnS & send}, 32'd0);
         if (e_busy) check($sformatf("idx j=%0d", j), idx, k);
         if (kind == 1 && j == inj) begin
            abort   = 1'b1;
            aborted = 1'b1;
            sw_ab   = e_sw;
         end
         if (kind == 2 && j == inj) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = AW'(1);
            wr_data = ~prog[1];
            exp_err = 1'b1;
         end
         if (kind == 3 && j == inj) begin
            #2 rst_n = 1'b0;
            #1;
            check("async_rst", {sw, btnS, send, busy, done, err, idx}, 32'd0);
            @(negedge clk);
            rst_n   = 1'b1;
            rst_hit = 1'b1;
            break;
         end
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         wr_en = 1'b0;
      end
      if (rst_hit) begin
         last_sw     = 8'h00;
         count_model = 0;
      end else if (aborted) last_sw = sw_ab;
      else if (neff > 0)    last_sw = prog[neff];
   endtask

   initial begin
      @(negedge clk);
      check("reset", {sw, btnS, send, busy, done, err, idx}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: PUSH then SEND
      prog[1] = 8'h04; prog[2] = 8'hC0; count_model = 2;
      load(2); play(0, 0);

      // 2: empty program
      count_model = 0;
      wr(0, 0); play(0, 0);

      // 3: abort during the second pulse
      prog[1] = 8'h04; prog[2] = 8'h13; prog[3] = 8'h52; count_model = 3;
      load(3); play(1, 12);

      // 4: start and write while busy, then replay to confirm the program is intact
      prog[1] = 8'($urandom); prog[2] = 8'($urandom); count_model = 2;
      load(2); play(2, 9); play(0, 0);

      // 5: oversized count clamps to the RAM size and flags an error
      for (int k = 1; k < DEPTH; k++) prog[k] = 8'($urandom);
      count_model = 20;
      load(20); play(0, 0);

      // 6: asynchronous reset mid-pulse, then reload and replay
      prog[1] = 8'h04; prog[2] = 8'h13; count_model = 2;
      load(2); play(3, 5);
      count_model = 2;
      load(2); play(0, 0);

      // Random programs
      for (int r = 0; r < 4; r++) begin
         count_model = int'($urandom_range(1, DEPTH - 1));
         for (int k = 1; k < DEPTH; k++) prog[k] = 8'($urandom);
         load(count_model); play(0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
